// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO controller: pointer width helper and default thresholds.
package fifo_pkg;
  localparam int DEF_ADDR_WIDTH    = 4;
  localparam int DEF_DEPTH         = 16;
  localparam int DEF_DATA_WIDTH    = 16;
  localparam int DEF_AFULL_THRESH  = 14;
  localparam int DEF_AEMPTY_THRESH = 2;
  localparam int PTR_W             = DEF_ADDR_WIDTH + 1;

  // Pointer carries one extra wrap bit above the memory address.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction
endpackage

// File: rtl/fifo_ptr.sv
// FIFO pointer register: increments by one, wraps naturally through the MSB, cleared by flush.
module fifo_ptr #(
  parameter int PTR_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (flush)
      ptr_d = '0;
    else if (inc)
      ptr_d = ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr_q <= '0;
    else
      ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
endmodule

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller driving an external registered-read memory.
// Optional sticky overflow/underflow flags are enabled with `define FIFO_CTRL_ERR_FLAGS_EN.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int DEPTH         = DEF_DEPTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int AFULL_THRESH  = DEF_AFULL_THRESH,
  parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  output logic                  mem_write_enable,
  output logic                  mem_read_enable,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);
  localparam int PW = ptr_width(ADDR_WIDTH);

  logic          wr_accept, rd_accept;
  logic [PW-1:0] wr_ptr, rd_ptr;

  logic [PW-1:0] count_d, count_q;
  logic          full_d, full_q;
  logic          empty_d, empty_q;
  logic          afull_d, afull_q;
  logic          aempty_d, aempty_q;
  logic          rd_valid_d, rd_valid_q;

  assign wr_accept = wr_en & ~full_q & ~flush;
  assign rd_accept = rd_en & ~empty_q & ~flush;

  fifo_ptr #(.PTR_W(PW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .inc   (wr_accept),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.PTR_W(PW)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .inc   (rd_accept),
    .ptr   (rd_ptr)
  );

  // Flags are computed from the next count so they line up with count itself.
  always_comb begin
    count_d = count_q;
    if (flush)
      count_d = '0;
    else if (wr_accept && !rd_accept)
      count_d = count_q + PW'(1);
    else if (rd_accept && !wr_accept)
      count_d = count_q - PW'(1);
    full_d     = (count_d == PW'(DEPTH));
    empty_d    = (count_d == '0);
    afull_d    = (count_d >= PW'(AFULL_THRESH));
    aempty_d   = (count_d <= PW'(AEMPTY_THRESH));
    rd_valid_d = rd_accept;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
      rd_valid_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
      rd_valid_q <= rd_valid_d;
    end
  end

`ifdef FIFO_CTRL_ERR_FLAGS_EN
  logic overflow_d, overflow_q;
  logic underflow_d, underflow_q;

  // Sticky until reset; flush deliberately leaves them alone.
  always_comb begin
    overflow_d  = overflow_q  | (wr_en & full_q  & ~flush);
    underflow_d = underflow_q | (rd_en & empty_q & ~flush);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign mem_write_enable = wr_accept;
  assign mem_read_enable  = rd_accept;
  assign mem_write_addr   = wr_ptr[ADDR_WIDTH-1:0];
  assign mem_read_addr    = rd_ptr[ADDR_WIDTH-1:0];
  assign mem_write_data   = wr_data;

  assign rd_data      = mem_read_data;
  assign rd_valid     = rd_valid_q;
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed scoreboard bench for fifo_ctrl with a behavioural registered-read memory alongside.
module tb_fifo_ctrl;
  localparam int AW = 4;
  localparam int DW = 16;

`ifdef FIFO_CTRL_ERR_FLAGS_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid, full, empty, almost_full, almost_empty;
  logic [AW:0]   count;
  logic          overflow, underflow;
  logic [AW-1:0] mem_write_addr, mem_read_addr;
  logic          mem_write_enable, mem_read_enable;
  logic [DW-1:0] mem_write_data, mem_read_data;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  fifo_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow),
    .mem_write_addr(mem_write_addr), .mem_read_addr(mem_read_addr),
    .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_write_addr] <= mem_write_data;
    if (mem_read_enable)  mem_read_data <= mem[mem_read_addr];
  end

  // Monitor: every rd_valid must match the oldest expected word.
  always @(negedge clk) begin
    if (rd_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rd_data_unexpected: got rd_valid with data 0x%04h, required no read", rd_data);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          n_bad++;
          $display("FAIL rd_data: got 0x%04h required 0x%04h", rd_data, e);
        end else
          $display("read  0x%04h ok", rd_data);
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    check("reset_count", int'(count), 0);
    check("reset_empty", int'(empty), 1);
    check("reset_full", int'(full), 0);
    check("reset_aempty", int'(almost_empty), 1);
    check("reset_afull", int'(almost_full), 0);
    check("reset_rd_valid", int'(rd_valid), 0);
    check("reset_overflow", int'(overflow), 0);
    check("reset_underflow", int'(underflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Fill to full.
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1; wr_data = DW'(i);
      exp_q.push_back(DW'(i));
      step();
      $display("write 0x%04h count=%0d", wr_data, count);
      check("fill_count", int'(count), i);
      check("fill_afull", int'(almost_full), (i >= 14) ? 1 : 0);
    end
    check("fill_full", int'(full), 1);
    check("fill_empty", int'(empty), 0);

    // Write while full: dropped.
    wr_data = 16'hDEAD;
    check("full_wr_gate", int'(mem_write_enable), 0);
    step();
    wr_en = 1'b0;
    $display("write 0x%04h while full count=%0d", wr_data, count);
    check("ovf_count", int'(count), 16);
    check("ovf_flag", int'(overflow), int'(ERR_EN));

    // Drain.
    for (int i = 1; i <= 16; i++) begin
      rd_en = 1'b1;
      step();
      check("drain_count", int'(count), 16 - i);
      check("drain_aempty", int'(almost_empty), (16 - i <= 2) ? 1 : 0);
    end
    rd_en = 1'b0;
    check("drain_empty", int'(empty), 1);
    check("drain_full", int'(full), 0);
    step();

    // Prime to 8 then stream both ways for 40 cycles.
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = DW'(16'h0100 + i);
      exp_q.push_back(wr_data);
      step();
    end
    check("prime_count", int'(count), 8);
    for (int i = 0; i < 40; i++) begin
      wr_en = 1'b1; rd_en = 1'b1; wr_data = DW'(16'h0200 + i);
      exp_q.push_back(wr_data);
      step();
      check("stream_count", int'(count), 8);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 8; i++) step();
    rd_en = 1'b0;
    check("stream_drained", int'(count), 0);
    step();

    // Read while empty.
    rd_en = 1'b1;
    check("empty_rd_gate", int'(mem_read_enable), 0);
    step();
    rd_en = 1'b0;
    $display("read request while empty count=%0d", count);
    check("unf_count", int'(count), 0);
    check("unf_flag", int'(underflow), int'(ERR_EN));
    step();
    check("unf_no_valid", int'(rd_valid), 0);

    // Five words, then flush with a concurrent write.
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = DW'(16'h0300 + i);
      step();
    end
    check("pre_flush_count", int'(count), 5);
    flush = 1'b1; wr_data = 16'hBEEF;
    step();
    flush = 1'b0; wr_en = 1'b0;
    $display("flush with write count=%0d", count);
    check("flush_count", int'(count), 0);
    check("flush_empty", int'(empty), 1);
    check("flush_full", int'(full), 0);
    check("flush_rd_valid", int'(rd_valid), 0);
    check("flush_keeps_ovf", int'(overflow), int'(ERR_EN));
    check("flush_keeps_unf", int'(underflow), int'(ERR_EN));
    wr_en = 1'b1; wr_data = 16'h0400;
    check("flush_wr_addr", int'(mem_write_addr), 0);
    exp_q.push_back(wr_data);
    step();
    wr_en = 1'b0; rd_en = 1'b1;
    check("flush_rd_addr", int'(mem_read_addr), 0);
    step();
    rd_en = 1'b0;
    step();

    // Reset mid-operation clears a pending rd_valid immediately.
    wr_en = 1'b1; wr_data = 16'h0500;
    step();
    wr_en = 1'b0; rd_en = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    rd_en = 1'b0;
    #1;
    $display("async reset mid-operation");
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_overflow", int'(overflow), 0);
    check("rst_underflow", int'(underflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Synchronous FIFO controller that sequences the flop-array FIFO memory (`mem_array`: registered read, write on clock edge). It owns the read/write pointers, occupancy count and status flags, gates requester reads and writes against full/empty, and drives the memory's address, enable and data ports. It sits between a producer/consumer pair and one `mem_array` instance in the transfer-test datapath.

## Interface
Parameters:
- ADDR_WIDTH, 4, memory address width
- DEPTH, 16, entries; must equal 2**ADDR_WIDTH
- DATA_WIDTH, 16, word width, passed through to memory
- AFULL_THRESH, 14, almost_full asserted when count >= this value
- AEMPTY_THRESH, 2, almost_empty asserted when count <= this value

Ports:
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of pointers and count
- wr_en  in  1  producer write request
- wr_data  in  DATA_WIDTH  producer data
- rd_en  in  1  consumer read request
- rd_data  out  DATA_WIDTH  read word, valid when rd_valid=1
- rd_valid  out  1  registered; read data valid
- full, empty, almost_full, almost_empty  out  1 each  status flags
- count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH
- overflow, underflow  out  1 each  sticky error flags (see Configuration)
- mem_write_addr, mem_read_addr  out  ADDR_WIDTH  to memory
- mem_write_enable, mem_read_enable  out  1  to memory
- mem_write_data  out  DATA_WIDTH  to memory
- mem_read_data  in  DATA_WIDTH  from memory

## Operation
- Pointers wr_ptr and rd_ptr are ADDR_WIDTH+1 bits; the low bits address memory and the MSB is the wrap bit. They wrap from DEPTH-1 to 0, toggling the MSB.
- wr_accept = wr_en & ~full & ~flush; rd_accept = rd_en & ~empty & ~flush.
- mem_write_enable = wr_accept and mem_read_enable = rd_accept, both combinational. mem_write_addr = wr_ptr[ADDR_WIDTH-1:0], mem_read_addr = rd_ptr[ADDR_WIDTH-1:0], mem_write_data = wr_data.
- rd_data = mem_read_data (passthrough). rd_valid is registered and equals rd_accept from the previous cycle.
- count update: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
- Flags are registered and derived from the next-state count: full = (count==DEPTH), empty = (count==0).
- Write while full is dropped, with no pointer change. Read while empty is dropped, and rd_valid stays 0.
- Both requested at full: the read is accepted and the write refused. Both requested at empty: the write is accepted and the read refused.
- flush has priority over all requests. Next cycle: pointers=0, count=0, empty=1, full=0, rd_valid=0. Memory contents are untouched, and the error flags are not cleared by flush.

## Timing
- Reset (rst_n=0, asynchronous): pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, rd_valid=0, overflow=0, underflow=0. Memory outputs are combinational from this state.
- Write-to-readable latency: a write accepted in cycle N makes empty=0 in cycle N+1, and a read can be accepted in N+1.
- Read latency: rd_accept in cycle N gives rd_valid=1 with data in cycle N+1.
- Back-to-back reads and writes sustain 1 word/cycle each.
- Reset asserted mid-operation discards all state immediately; a pending rd_valid is cleared.

## Configuration
- Macro FIFO_CTRL_ERR_FLAGS_EN:
  - Defined: overflow is set on wr_en & full & ~flush, and underflow on rd_en & empty & ~flush. Both are sticky until rst_n.
  - Undefined: overflow and underflow are tied to 0 and no error logic is synthesized.

## Structure
- Shared package fifo_pkg holds the pointer width helper constant (PTR_W = ADDR_WIDTH+1) and the default threshold constants.
- One sub-module, fifo_ptr: pointer register with increment, wrap and flush. It is instantiated twice, once for write and once for read.
- Count, flags and error logic live in fifo_ctrl.
- fifo_ctrl does not instantiate the memory; the memory is wired alongside it at the level above.

## Test plan
- Reset, then write 16 words 0x0001..0x0010 -> full=1 and count=16 after the 16th write; almost_full rises when count reaches 14.
- Read 16 words from full -> rd_data 0x0001..0x0010 in order, one cycle after each rd_en; empty=1 after the last read; almost_empty rises when count reaches 2.
- Write 17th word while full (macro defined) -> word dropped, count stays 16, overflow=1 and stays set through flush.
- Simultaneous wr_en/rd_en at count=8 for 40 cycles -> count stays 8, pointers wrap past 15 more than once, data order preserved.
- rd_en while empty, then flush with wr_en at count=5 -> no rd_valid, underflow=1 (macro defined); next cycle count=0, empty=1, and the write is ignored.
